conv_layer_mem: RTL and testbench

// - Responder for the CONV engine's layer-memory interface (cwr/caddr_wr/cdata_wr, crd/caddr_rd/cdata_rd, csel).
// - Holds two banks: L0 (64x64 conv results, csel=3'b001) and L1 (32x32 max-pool results, csel=3'b011).
// - Adds a host dump port that streams a whole bank out after CONV drops busy, plus sticky protocol-error flags
//   and per-bank write counters.

---
 rtl/conv_mem_pkg.sv | 14 +
 rtl/conv_layer_mem_if.sv | 32 +++
 rtl/lm_bank.sv | 25 ++
 rtl/conv_layer_mem.sv | 116 +++++++++++
 tb/tb_conv_layer_mem.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_mem_pkg.sv
// Shared constants and types for the CONV layer memory.
package conv_mem_pkg;
    localparam int DATA_W   = 20;
    localparam int ADDR_W   = 12;
    localparam int L0_DEPTH = 4096;
    localparam int L1_DEPTH = 1024;

    localparam logic [2:0]        CSEL_L0 = 3'b001;
    localparam logic [2:0]        CSEL_L1 = 3'b011;
    localparam logic [ADDR_W-1:0] L0_LAST = 12'd4095;
    localparam logic [ADDR_W-1:0] L1_LAST = 12'd1023;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} dump_state_t;
endpackage

// File: rtl/conv_layer_mem_if.sv
// CONV engine layer-memory bus plus the host dump stream.
interface conv_layer_mem_if;
    import conv_mem_pkg::*;

    logic              busy;
    logic [2:0]        csel;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic [DATA_W-1:0] cdata_wr;
    logic              crd;
    logic [ADDR_W-1:0] caddr_rd;
    logic [DATA_W-1:0] cdata_rd;
    logic              dump_req;
    logic              dump_sel;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;

    modport master (
        output busy, csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd,
               dump_req, dump_sel, dump_ready,
        input  cdata_rd, dump_valid, dump_addr, dump_data, dump_done
    );

    modport slave (
        input  busy, csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd,
               dump_req, dump_sel, dump_ready,
        output cdata_rd, dump_valid, dump_addr, dump_data, dump_done
    );
endinterface

// File: rtl/lm_bank.sv
// Layer memory bank: synchronous write, two combinational read ports.
module lm_bank #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 20,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Reads see the pre-edge contents, so a same-cycle write returns the old word.
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/conv_layer_mem.sv
// CONV layer memory responder: L0/L1 banks, error flags, write counters, bank dump.
//  state  | meaning
//  IDLE   | waiting for dump_req while CONV is not busy
//  LOAD   | registering bank[idx] into dump_data
//  STREAM | beat presented, waiting for dump_ready
//  DONE   | one-cycle dump_done pulse
module conv_layer_mem
    import conv_mem_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    conv_layer_mem_if.slave bus,
    output logic [12:0]     wr_cnt_l0,
    output logic [10:0]     wr_cnt_l1,
    output logic            err_csel,
    output logic            err_rw,
    output logic            err_conflict
);
    dump_state_t       state_q, state_d;
    logic              sel_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] data_q;
    logic              start, load_en, advance, is_last;
    logic              dump_valid, dump_done;
    logic [DATA_W-1:0] rd_l0, rd_l1, dump_l0, dump_l1;

    logic sel_l0, sel_l1, csel_bad, l1_addr_ok, we_l0, we_l1;
    assign sel_l0     = (bus.csel == CSEL_L0);
    assign sel_l1     = (bus.csel == CSEL_L1);
    assign csel_bad   = !sel_l0 && !sel_l1;
    assign l1_addr_ok = (bus.caddr_wr[11:10] == 2'b00);
    assign we_l0      = bus.cwr && sel_l0;
    assign we_l1      = bus.cwr && sel_l1 && l1_addr_ok;

    lm_bank #(.DEPTH(L0_DEPTH), .DATA_W(DATA_W)) u_l0 (
        .clk(clk), .we(we_l0), .waddr(bus.caddr_wr), .wdata(bus.cdata_wr),
        .raddr_a(bus.caddr_rd), .rdata_a(rd_l0),
        .raddr_b(idx_q), .rdata_b(dump_l0)
    );

    lm_bank #(.DEPTH(L1_DEPTH), .DATA_W(DATA_W)) u_l1 (
        .clk(clk), .we(we_l1), .waddr(bus.caddr_wr[9:0]), .wdata(bus.cdata_wr),
        .raddr_a(bus.caddr_rd[9:0]), .rdata_a(rd_l1),
        .raddr_b(idx_q[9:0]), .rdata_b(dump_l1)
    );

    always_comb begin
        bus.cdata_rd = '0;
        if (bus.crd && sel_l0)      bus.cdata_rd = rd_l0;
        else if (bus.crd && sel_l1) bus.cdata_rd = rd_l1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_csel     <= 1'b0;
            err_rw       <= 1'b0;
            err_conflict <= 1'b0;
            wr_cnt_l0    <= '0;
            wr_cnt_l1    <= '0;
        end else begin
            if (((bus.cwr || bus.crd) && csel_bad) || (bus.cwr && sel_l1 && !l1_addr_ok))
                err_csel <= 1'b1;
            if (bus.cwr && bus.crd) err_rw <= 1'b1;
            if (bus.cwr && (state_q == LOAD || state_q == STREAM)) err_conflict <= 1'b1;
            if (we_l0 && wr_cnt_l0 != '1) wr_cnt_l0 <= wr_cnt_l0 + 13'd1;
            if (we_l1 && wr_cnt_l1 != '1) wr_cnt_l1 <= wr_cnt_l1 + 11'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign is_last = (idx_q == (sel_q ? L1_LAST : L0_LAST));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.dump_req && !bus.busy) state_d = LOAD;
            LOAD:    state_d = STREAM;
            STREAM:  if (bus.dump_ready) state_d = is_last ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start      = (state_q == IDLE) && bus.dump_req && !bus.busy;
        load_en    = (state_q == LOAD);
        advance    = (state_q == STREAM) && bus.dump_ready && !is_last;
        dump_valid = (state_q == STREAM);
        dump_done  = (state_q == DONE);
    end

    // Beat datapath; a write landing after LOAD does not disturb the held beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q  <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            if (start) begin
                sel_q <= bus.dump_sel;
                idx_q <= '0;
            end
            if (load_en) data_q <= sel_q ? dump_l1 : dump_l0;
            if (advance) idx_q <= idx_q + 12'd1;
        end
    end

    assign bus.dump_valid = dump_valid;
    assign bus.dump_done  = dump_done;
    assign bus.dump_addr  = idx_q;
    assign bus.dump_data  = data_q;
endmodule

// File: tb/tb_conv_layer_mem.sv
// Randomized self-checking bench for conv_layer_mem against a behavioural memory model.
module tb_conv_layer_mem;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] wr_cnt_l0;
    logic [10:0] wr_cnt_l1;
    logic        err_csel, err_rw, err_conflict;

    conv_layer_mem_if bus();

    conv_layer_mem dut (
        .clk(clk), .reset(reset), .bus(bus),
        .wr_cnt_l0(wr_cnt_l0), .wr_cnt_l1(wr_cnt_l1),
        .err_csel(err_csel), .err_rw(err_rw), .err_conflict(err_conflict)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0] l0_m [4096];
    logic [19:0] l1_m [1024];
    int m_cnt0 = 0, m_cnt1 = 0;
    bit m_err_csel = 0, m_err_rw = 0, m_err_conflict = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] model_rd(input logic [2:0] cs, input logic rd, input logic [11:0] a);
        if (!rd) return 20'h0;
        if (cs == 3'b001) return l0_m[a];
        if (cs == 3'b011) return l1_m[a[9:0]];
        return 20'h0;
    endfunction

    task automatic model_step(input logic [2:0] cs, input logic wr, input logic [11:0] aw,
                              input logic [19:0] dw, input logic rd, input bit in_dump);
        if ((wr || rd) && cs != 3'b001 && cs != 3'b011) m_err_csel = 1;
        if (wr && rd) m_err_rw = 1;
        if (wr && in_dump) m_err_conflict = 1;
        if (wr && cs == 3'b001) begin
            l0_m[aw] = dw;
            if (m_cnt0 < 8191) m_cnt0++;
        end
        if (wr && cs == 3'b011) begin
            if (aw[11:10] != 2'b00) m_err_csel = 1;
            else begin
                l1_m[aw[9:0]] = dw;
                if (m_cnt1 < 2047) m_cnt1++;
            end
        end
    endtask

    task automatic model_reset();
        m_cnt0 = 0; m_cnt1 = 0;
        m_err_csel = 0; m_err_rw = 0; m_err_conflict = 0;
    endtask

    task automatic check_status();
        check("wr_cnt_l0", 32'(wr_cnt_l0), 32'(m_cnt0));
        check("wr_cnt_l1", 32'(wr_cnt_l1), 32'(m_cnt1));
        check("err_csel", 32'(err_csel), 32'(m_err_csel));
        check("err_rw", 32'(err_rw), 32'(m_err_rw));
        check("err_conflict", 32'(err_conflict), 32'(m_err_conflict));
    endtask

    task automatic check_reset_outputs();
        check("rst_dump_valid", 32'(bus.dump_valid), 0);
        check("rst_dump_done", 32'(bus.dump_done), 0);
        check("rst_dump_addr", 32'(bus.dump_addr), 0);
        check("rst_dump_data", 32'(bus.dump_data), 0);
        check("rst_cdata_rd", 32'(bus.cdata_rd), 0);
        check_status();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic bus_cycle(input logic [2:0] cs, input logic wr, input logic [11:0] aw,
                             input logic [19:0] dw, input logic rd, input logic [11:0] ar);
        @(negedge clk);
        check_status();
        bus.csel = cs; bus.cwr = wr; bus.caddr_wr = aw; bus.cdata_wr = dw;
        bus.crd = rd; bus.caddr_rd = ar;
        #1;
        check("cdata_rd", 32'(bus.cdata_rd), 32'(model_rd(cs, rd, ar)));
        model_step(cs, wr, aw, dw, rd, 1'b0);
        @(posedge clk);
        #1;
        bus.cwr = 1'b0; bus.crd = 1'b0;
    endtask

    task automatic dump_run(input bit sel, input int abort_at, input bit conflict);
        int n, beat, seen, dones;
        logic [19:0] cur_exp, dw;
        bit conf_done, rdy;
        n = sel ? 1024 : 4096;
        beat = 0; seen = -1; dones = 0; conf_done = 0; cur_exp = '0;
        @(negedge clk);
        bus.dump_req = 1'b1; bus.dump_sel = sel; bus.dump_ready = 1'b0;
        @(posedge clk);
        #1 bus.dump_req = 1'b0;
        for (int cyc = 0; cyc < n * 6 + 50; cyc++) begin
            @(negedge clk);
            bus.cwr = 1'b0;
            if (bus.dump_done) begin
                dones++;
                check("done_valid", 32'(bus.dump_valid), 0);
                break;
            end
            rdy = 1'($urandom);
            if (bus.dump_valid) begin
                if (beat >= n) begin
                    check("dump_extra", 32'(bus.dump_valid), 0);
                    break;
                end
                if (beat != seen) begin
                    seen = beat;
                    cur_exp = sel ? l1_m[10'(beat)] : l0_m[12'(beat)];
                end
                check("dump_addr", 32'(bus.dump_addr), 32'(beat));
                check("dump_data", 32'(bus.dump_data), 32'(cur_exp));
                if (beat == abort_at) begin
                    reset = 1'b1;
                    #1;
                    check("abort_valid", 32'(bus.dump_valid), 0);
                    model_reset();
                    bus.dump_ready = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        reset = 1'b0;
                        check("abort_no_done", 32'(bus.dump_done), 0);
                        check("abort_idle", 32'(bus.dump_valid), 0);
                    end
                    return;
                end
                if (conflict && beat == 50 && !conf_done) begin
                    rdy = 1'b0;
                    conf_done = 1;
                    dw = 20'($urandom);
                    bus.csel = 3'b011; bus.cwr = 1'b1; bus.caddr_wr = 12'(beat); bus.cdata_wr = dw;
                    model_step(3'b011, 1'b1, 12'(beat), dw, 1'b0, 1'b1);
                end
                bus.dump_ready = rdy;
                if (rdy) beat++;
            end else begin
                bus.dump_ready = rdy;
            end
        end
        bus.cwr = 1'b0;
        bus.dump_ready = 1'b0;
        check("dump_beats", 32'(beat), 32'(n));
        check("dump_done_cnt", 32'(dones), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("done_single", 32'(bus.dump_done), 0);
            check("post_idle", 32'(bus.dump_valid), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  cs;
        logic [11:0] aw, ar;
        int r;
        bus.busy = 1'b0; bus.csel = 3'b000; bus.cwr = 1'b0; bus.caddr_wr = '0; bus.cdata_wr = '0;
        bus.crd = 1'b0; bus.caddr_rd = '0; bus.dump_req = 1'b0; bus.dump_sel = 1'b0; bus.dump_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        // L0 write then read back
        bus_cycle(3'b001, 1, 12'h041, 20'h12345, 0, 12'h000);
        bus_cycle(3'b001, 0, 12'h000, 20'h00000, 1, 12'h041);

        // L1 top address, then out-of-range write dropped
        bus_cycle(3'b011, 1, 12'h3FF, 20'hABCDE, 0, 12'h000);
        bus_cycle(3'b011, 1, 12'h000, 20'h0F0F0, 0, 12'h000);
        bus_cycle(3'b011, 1, 12'h041, 20'h55555, 0, 12'h000);
        bus_cycle(3'b011, 0, 12'h000, 20'h00000, 1, 12'h3FF);
        bus_cycle(3'b011, 1, 12'h400, 20'h99999, 0, 12'h000);
        bus_cycle(3'b011, 0, 12'h000, 20'h00000, 1, 12'h000);

        // Illegal csel, then simultaneous strobes
        do_reset();
        bus_cycle(3'b010, 1, 12'h041, 20'hFFFFF, 0, 12'h000);
        bus_cycle(3'b001, 0, 12'h000, 20'h00000, 1, 12'h041);
        bus_cycle(3'b011, 0, 12'h000, 20'h00000, 1, 12'h041);
        bus_cycle(3'b010, 0, 12'h000, 20'h00000, 1, 12'h041);
        bus_cycle(3'b001, 1, 12'h041, 20'h0BEEF, 1, 12'h041);
        bus_cycle(3'b001, 0, 12'h000, 20'h00000, 1, 12'h041);

        // Same-address collision returns the old word
        bus_cycle(3'b001, 1, 12'h010, 20'h00000, 0, 12'h000);
        bus_cycle(3'b001, 1, 12'h010, 20'h00001, 1, 12'h010);
        bus_cycle(3'b001, 0, 12'h000, 20'h00000, 1, 12'h010);

        for (int i = 0; i < 256; i++)
            bus_cycle(3'b001, 1, 12'(i), 20'($urandom), 0, 12'h000);
        for (int i = 0; i < 1024; i++)
            bus_cycle(3'b011, 1, 12'(i), 20'($urandom), 0, 12'h000);

        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 7);
            cs = (r < 3) ? 3'b001 : (r < 6) ? 3'b011 : 3'($urandom);
            if (cs == 3'b001) begin
                aw = 12'($urandom_range(0, 255));
                ar = 12'($urandom_range(0, 255));
            end else begin
                aw = 12'($urandom_range(0, 1023));
                if ($urandom_range(0, 7) == 0) aw[11:10] = 2'($urandom_range(1, 3));
                ar = 12'($urandom_range(0, 1023));
            end
            bus_cycle(cs, 1'($urandom), aw, 20'($urandom), 1'($urandom), ar);
        end

        // dump_req while busy is ignored
        @(negedge clk);
        bus.busy = 1'b1; bus.dump_req = 1'b1; bus.dump_sel = 1'b1;
        @(negedge clk);
        bus.dump_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("busy_no_valid", 32'(bus.dump_valid), 0);
        end
        bus.busy = 1'b0;

        for (int i = 0; i < 1024; i++)
            bus_cycle(3'b011, 1, 12'(i), 20'(i), 0, 12'h000);
        dump_run(1'b1, -1, 1'b1);
        @(negedge clk);
        check_status();

        dump_run(1'b0, 100, 1'b0);
        dump_run(1'b0, 3, 1'b0);
        @(negedge clk);
        check_status();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
